// File: rtl/phv_stage_fifo.sv
// phv_stage_fifo: elastic FWFT PHV buffer between RMT stages; define PHV_FIFO_DROP_CNT_EN to add the phv_drop_cnt port
module phv_stage_fifo #(
   parameter int PHV_LEN  = 1124,
   parameter int DEPTH    = 4,
   parameter int AF_LEVEL = 3
) (
   input  logic                     axis_clk,
   input  logic                     areset,
   input  logic [PHV_LEN-1:0]       phv_in,
   input  logic                     phv_in_valid,
   output logic                     phv_in_ready,
   output logic                     phv_almost_full,
   output logic [PHV_LEN-1:0]       phv_out,
   output logic                     phv_out_valid,
   input  logic                     stg_ready,
   output logic [$clog2(DEPTH):0]   fifo_count
`ifdef PHV_FIFO_DROP_CNT_EN
   ,
   output logic [31:0]              phv_drop_cnt
`endif
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   logic [PHV_LEN-1:0] r_mem [DEPTH];
   logic [PW-1:0]      r_rd_ptr, r_wr_ptr;
   logic [CW-1:0]      r_count;
   logic               r_valid, r_ready, r_af;
   logic [PHV_LEN-1:0] r_phv_out;
   logic               w_push, w_pop;
   logic [PW-1:0]      w_rd_next;
   logic [CW-1:0]      w_cnt_next;
   logic [PHV_LEN-1:0] w_head_next;
   // next-state: handshakes, occupancy and the entry that becomes head (bypass when it is being written now)
   always_comb begin
      w_push      = phv_in_valid & r_ready;
      w_pop       = r_valid & stg_ready;
      w_rd_next   = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
      w_cnt_next  = r_count + CW'(w_push) - CW'(w_pop);
      w_head_next = (w_push && w_rd_next == r_wr_ptr) ? phv_in : r_mem[w_rd_next];
   end
   // storage RAM, intentionally not reset
   always_ff @(posedge axis_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= phv_in;
   end
   // pointers, occupancy and registered status/head outputs
   always_ff @(posedge axis_clk or posedge areset) begin
      if (areset) begin
         r_rd_ptr  <= '0;
         r_wr_ptr  <= '0;
         r_count   <= '0;
         r_valid   <= 1'b0;
         r_ready   <= 1'b1;
         r_af      <= 1'b0;
         r_phv_out <= '0;
      end else begin
         r_rd_ptr  <= w_rd_next;
         r_wr_ptr  <= w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
         r_count   <= w_cnt_next;
         r_valid   <= w_cnt_next != '0;
         r_ready   <= w_cnt_next != CW'(DEPTH);
         r_af      <= w_cnt_next >= CW'(AF_LEVEL);
         if (w_cnt_next != '0) r_phv_out <= w_head_next;
      end
   end
`ifdef PHV_FIFO_DROP_CNT_EN
   logic [31:0] r_drop_cnt;
   // saturating count of cycles where upstream offered a PHV while full
   always_ff @(posedge axis_clk or posedge areset) begin
      if (areset) r_drop_cnt <= '0;
      else if (phv_in_valid && !r_ready && r_drop_cnt != 32'hFFFF_FFFF) r_drop_cnt <= r_drop_cnt + 1'b1;
   end
   assign phv_drop_cnt = r_drop_cnt;
`endif
   assign phv_in_ready    = r_ready;
   assign phv_almost_full = r_af;
   assign phv_out         = r_phv_out;
   assign phv_out_valid   = r_valid;
   assign fifo_count      = r_count;
endmodule

// File: tb/tb_phv_stage_fifo.sv
// tb_phv_stage_fifo: directed self-checking bench for phv_stage_fifo (honours PHV_FIFO_DROP_CNT_EN)
module tb_phv_stage_fifo;
   localparam int PL = 1124;
   logic          axis_clk = 1'b0;
   logic          areset = 1'b1;
   logic [PL-1:0] phv_in = '0;
   logic          phv_in_valid = 1'b0;
   logic          phv_in_ready;
   logic          phv_almost_full;
   logic [PL-1:0] phv_out;
   logic          phv_out_valid;
   logic          stg_ready = 1'b0;
   logic [2:0]    fifo_count;
   int            checks = 0;
   int            failures = 0;
`ifdef PHV_FIFO_DROP_CNT_EN
   logic [31:0]   phv_drop_cnt;
`endif
   phv_stage_fifo dut (
      .axis_clk(axis_clk), .areset(areset), .phv_in(phv_in), .phv_in_valid(phv_in_valid),
      .phv_in_ready(phv_in_ready), .phv_almost_full(phv_almost_full), .phv_out(phv_out),
      .phv_out_valid(phv_out_valid), .stg_ready(stg_ready), .fifo_count(fifo_count)
`ifdef PHV_FIFO_DROP_CNT_EN
      , .phv_drop_cnt(phv_drop_cnt)
`endif
   );
   always #5 axis_clk = ~axis_clk;
   function automatic logic [PL-1:0] mk(input logic [31:0] t);
      return {t[3:0], {35{t}}};
   endfunction
   task automatic chk(input string tag, input logic [PL-1:0] obs, input logic [PL-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs[63:0], exp[63:0]);
      end
   endtask
   task automatic step();
      @(posedge axis_clk);
      #1;
   endtask
   task automatic chk_state(input string tag, input logic v, input int c, input logic r, input logic af);
      chk({tag, "_valid"}, phv_out_valid, v);
      chk({tag, "_count"}, fifo_count, c);
      chk({tag, "_ready"}, phv_in_ready, r);
      chk({tag, "_af"}, phv_almost_full, af);
   endtask
   initial begin
      int sent, got, c;
      repeat (2) step();
      chk_state("reset", 0, 0, 1, 0);
      chk("reset_phv_out", phv_out, '0);
      areset = 1'b0;
      step();
      // single PHV: one-cycle latency, popped on the next edge
      phv_in = mk(32'hA5); phv_in_valid = 1'b1; stg_ready = 1'b1;
      step();
      chk_state("single1", 1, 1, 1, 0);
      chk("single1_data", phv_out, mk(32'hA5));
      phv_in_valid = 1'b0;
      step();
      chk_state("single2", 0, 0, 1, 0);
      // backpressure fill: 5 offered, 4 stored, 5th dropped
      stg_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         phv_in = mk(i); phv_in_valid = 1'b1;
         step();
         chk_state($sformatf("fill%0d", i), 1, (i < 4) ? i : 4, i < 4, i >= 3);
         chk($sformatf("fill%0d_head", i), phv_out, mk(1));
      end
`ifdef PHV_FIFO_DROP_CNT_EN
      chk("drop_after_fill", phv_drop_cnt, 1);
`endif
      // full with simultaneous pop: offered PHV still dropped
      phv_in = mk(99); phv_in_valid = 1'b1; stg_ready = 1'b1;
      step();
      chk_state("fullpop", 1, 3, 1, 1);
      chk("fullpop_head", phv_out, mk(2));
      phv_in_valid = 1'b0;
`ifdef PHV_FIFO_DROP_CNT_EN
      chk("drop_after_fullpop", phv_drop_cnt, 2);
`endif
      // drain remaining in order
      step();
      chk_state("drain3", 1, 2, 1, 0);
      chk("drain3_head", phv_out, mk(3));
      step();
      chk_state("drain4", 1, 1, 1, 0);
      chk("drain4_head", phv_out, mk(4));
      step();
      chk_state("drained", 0, 0, 1, 0);
      // streaming with stg_ready 1-0-1, pushing only when ready
      sent = 0; got = 0; c = 0;
      while (got < 64 && c < 400) begin
         stg_ready = (c % 3) != 1;
         if (sent < 64 && phv_in_ready) begin
            phv_in = mk(100 + sent); phv_in_valid = 1'b1; sent++;
         end else phv_in_valid = 1'b0;
         if (phv_out_valid && stg_ready) begin
            chk("stream_order", phv_out, mk(100 + got));
            got++;
         end
         step();
         chk("stream_count_le4", fifo_count <= 3'd4, 1);
         c++;
      end
      phv_in_valid = 1'b0; stg_ready = 1'b0;
      chk("stream_all_out", got, 64);
      chk("stream_all_in", sent, 64);
      step();
      chk_state("stream_end", 0, 0, 1, 0);
`ifdef PHV_FIFO_DROP_CNT_EN
      chk("drop_after_stream", phv_drop_cnt, 2);
`endif
      // reset mid-operation: asynchronous clear
      for (int i = 0; i < 3; i++) begin
         phv_in = mk(200 + i); phv_in_valid = 1'b1;
         step();
      end
      phv_in_valid = 1'b0;
      chk_state("pre_reset", 1, 3, 1, 1);
      #2 areset = 1'b1;
      #1;
      chk_state("async_reset", 0, 0, 1, 0);
      chk("async_reset_phv_out", phv_out, '0);
`ifdef PHV_FIFO_DROP_CNT_EN
      chk("async_reset_drop", phv_drop_cnt, 0);
`endif
      step();
      areset = 1'b0;
      step();
      chk_state("post_reset", 0, 0, 1, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
